// File: rtl/fetch_ctl.sv
// Instruction-fetch controller: owns the PC and drives the stalling instruction-memory
// handshake. It keeps a one-entry skid buffer and loads the IF/ID register that feeds decode.
module fetch_ctl #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        PCSrc,
    input  logic [15:0] Branch_PC,
    input  logic        Halt,
    output logic [15:0] imem_addr,
    output logic        imem_rd,
    input  logic        imem_stall,
    input  logic        imem_done,
    input  logic [15:0] imem_data,
    output logic [15:0] instruct,
    output logic [15:0] PCInc,
    output logic        if_valid,
    output logic        halted,
    output logic        err
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL, S_HALTED} state_t;

    state_t      state, state_next;
    logic [15:0] pc;
    logic [15:0] pc_inc;
    logic [15:0] skid_instr;
    logic [15:0] skid_pcinc;
    logic        squash;
    logic        live;
    logic        accept;
    logic        deliver;
    logic        redir;
    logic        hlt;
    logic        outstanding;
    logic        err_evt;

    assign pc_inc    = pc + 16'd2;
    assign imem_addr = pc;

    // A squashed response never counts as a delivery; it only returns the FSM to REQ.
    assign live        = (state != S_HALTED);
    assign accept      = (state == S_REQ) & ~imem_stall;
    assign deliver     = (accept & imem_done) | ((state == S_WAIT) & imem_done & ~squash);
    assign redir       = live & PCSrc & if_valid & ~stall;
    assign hlt         = live & Halt & if_valid & ~stall & ~PCSrc;
    assign outstanding = ~imem_done & (accept | (state == S_WAIT));
    assign err_evt     = imem_done & (((state == S_REQ) & imem_stall) |
                                      (state == S_FULL) |
                                      ((state == S_HALTED) & ~squash));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (state == S_HALTED) begin
            state_next = S_HALTED;
        end else if (hlt) begin
            state_next = S_HALTED;
        end else if (redir) begin
            state_next = outstanding ? S_WAIT : S_REQ;
        end else begin
            case (state)
                S_REQ: begin
                    if (accept) begin
                        if (!imem_done)  state_next = S_WAIT;
                        else if (stall)  state_next = S_FULL;
                        else             state_next = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_done) state_next = (squash | ~stall) ? S_REQ : S_FULL;
                end
                S_FULL: begin
                    if (!stall) state_next = S_REQ;
                end
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        imem_rd = (state == S_REQ);
        halted  = (state == S_HALTED);
    end

    // Redirect and halt both flush IF/ID; squash remembers a response still in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc         <= RESET_PC;
            instruct   <= NOP_INSTR;
            PCInc      <= 16'h0000;
            if_valid   <= 1'b0;
            squash     <= 1'b0;
            skid_instr <= NOP_INSTR;
            skid_pcinc <= 16'h0000;
            err        <= 1'b0;
        end else begin
            err <= err | err_evt;
            if (hlt | redir) begin
                squash   <= outstanding;
                instruct <= NOP_INSTR;
                if_valid <= 1'b0;
                if (redir) pc <= Branch_PC;
            end else begin
                if (imem_done && (state == S_WAIT || state == S_HALTED)) squash <= 1'b0;
                if (deliver) pc <= pc_inc;
                if (deliver && stall) begin
                    skid_instr <= imem_data;
                    skid_pcinc <= pc_inc;
                end
                if (!stall) begin
                    if (deliver) begin
                        instruct <= imem_data;
                        PCInc    <= pc_inc;
                        if_valid <= 1'b1;
                    end else if (state == S_FULL) begin
                        instruct <= skid_instr;
                        PCInc    <= skid_pcinc;
                        if_valid <= 1'b1;
                    end else begin
                        instruct <= NOP_INSTR;
                        if_valid <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctl.sv
// Directed bench for fetch_ctl: delivered instructions are queued when the memory
// returns them and popped when they appear in IF/ID.
module tb_fetch_ctl;

    localparam logic [15:0] NOP = 16'h0800;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pcinc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        pc_src = 1'b0;
    logic [15:0] branch_pc = 16'h0000;
    logic        halt = 1'b0;
    logic        imem_stall = 1'b0;
    logic        imem_done = 1'b0;
    logic [15:0] imem_data = 16'h0000;
    logic [15:0] imem_addr;
    logic        imem_rd;
    logic [15:0] instruct;
    logic [15:0] pc_inc;
    logic        if_valid;
    logic        halted;
    logic        err;

    logic        rst_w = 1'b1;
    logic        stall_w = 1'b0;
    logic        imem_done_w = 1'b0;
    logic [15:0] imem_data_w = 16'h0000;
    logic [15:0] imem_addr_w;
    logic        imem_rd_w;
    logic [15:0] instruct_w;
    logic [15:0] pc_inc_w;
    logic        if_valid_w;
    logic        halted_w;
    logic        err_w;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    fetch_ctl dut (
        .clk(clk), .rst(rst), .stall(stall), .PCSrc(pc_src), .Branch_PC(branch_pc),
        .Halt(halt), .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_stall(imem_stall),
        .imem_done(imem_done), .imem_data(imem_data), .instruct(instruct), .PCInc(pc_inc),
        .if_valid(if_valid), .halted(halted), .err(err)
    );

    fetch_ctl #(.RESET_PC(16'hFFFE)) dut_w (
        .clk(clk), .rst(rst_w), .stall(stall_w), .PCSrc(1'b0), .Branch_PC(16'h0000),
        .Halt(1'b0), .imem_addr(imem_addr_w), .imem_rd(imem_rd_w), .imem_stall(1'b0),
        .imem_done(imem_done_w), .imem_data(imem_data_w), .instruct(instruct_w),
        .PCInc(pc_inc_w), .if_valid(if_valid_w), .halted(halted_w), .err(err_w)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic st, input logic ims, input logic done,
                                 input logic [15:0] data);
        stall      = st;
        imem_stall = ims;
        imem_done  = done;
        imem_data  = data;
    endtask

    task automatic pushExp(input logic [15:0] instr, input logic [15:0] pcinc);
        exp_t e;
        e.instr = instr;
        e.pcinc = pcinc;
        exp_q.push_back(e);
    endtask

    task automatic popCheck(input string tag, input logic [15:0] instr_obs,
                            input logic [15:0] pcinc_obs, input logic valid_obs);
        exp_t e;
        if (exp_q.size() == 0) begin
            checkOutput({tag, "_queue_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            checkOutput({tag, "_valid"}, {31'd0, valid_obs}, 32'd1);
            checkOutput({tag, "_instr"}, {16'd0, instr_obs}, {16'd0, e.instr});
            checkOutput({tag, "_pcinc"}, {16'd0, pcinc_obs}, {16'd0, e.pcinc});
        end
    endtask

    task automatic resetMain();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        tick();
        checkOutput("rst_addr", {16'd0, imem_addr}, 32'h0000);
        checkOutput("rst_instr", {16'd0, instruct}, {16'd0, NOP});
        checkOutput("rst_pcinc", {16'd0, pc_inc}, 32'h0000);
        checkOutput("rst_valid", {31'd0, if_valid}, 32'd0);
        checkOutput("rst_halted", {31'd0, halted}, 32'd0);
        checkOutput("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b1;
    endtask

    initial begin
        logic [15:0] hit_data [3];
        hit_data[0] = 16'h1111;
        hit_data[1] = 16'h2222;
        hit_data[2] = 16'h3333;
        #2;
        rst   = 1'b0;
        rst_w = 1'b0;

        // Back-to-back hits
        resetMain();
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("hit%0d_rd", i), {31'd0, imem_rd}, 32'd1);
            checkOutput($sformatf("hit%0d_addr", i), {16'd0, imem_addr}, 32'(2 * i));
            applyStimulus(1'b0, 1'b0, 1'b1, hit_data[i]);
            pushExp(hit_data[i], 16'(2 * i + 2));
            tick();
            popCheck($sformatf("hit%0d", i), instruct, pc_inc, if_valid);
        end

        // Miss answered four cycles after acceptance
        resetMain();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("miss%0d_valid", k), {31'd0, if_valid}, 32'd0);
            checkOutput($sformatf("miss%0d_instr", k), {16'd0, instruct}, {16'd0, NOP});
            checkOutput($sformatf("miss%0d_rd", k), {31'd0, imem_rd}, 32'd0);
            if (k == 3) begin
                applyStimulus(1'b0, 1'b0, 1'b1, 16'hA5A5);
                pushExp(16'hA5A5, 16'h0002);
            end
            tick();
        end
        popCheck("miss", instruct, pc_inc, if_valid);
        checkOutput("miss_next_addr", {16'd0, imem_addr}, 32'h0002);
        checkOutput("miss_next_rd", {31'd0, imem_rd}, 32'd1);

        // Hit returns while decode is stalled: word parks in the skid buffer
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h5A5A);
        pushExp(16'h5A5A, 16'h0004);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("stall%0d_instr", k), {16'd0, instruct}, 32'hA5A5);
            checkOutput($sformatf("stall%0d_pcinc", k), {16'd0, pc_inc}, 32'h0002);
            checkOutput($sformatf("stall%0d_rd", k), {31'd0, imem_rd}, 32'd0);
            if (k == 2) stall = 1'b0;
            else tick();
        end
        tick();
        popCheck("skid", instruct, pc_inc, if_valid);
        checkOutput("skid_next_addr", {16'd0, imem_addr}, 32'h0004);
        checkOutput("skid_next_rd", {31'd0, imem_rd}, 32'd1);

        // Redirect while a miss is being accepted: its late response must be dropped
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        pc_src    = 1'b1;
        branch_pc = 16'h0040;
        tick();
        pc_src = 1'b0;
        checkOutput("redir_valid", {31'd0, if_valid}, 32'd0);
        checkOutput("redir_instr", {16'd0, instruct}, {16'd0, NOP});
        checkOutput("redir_rd", {31'd0, imem_rd}, 32'd0);
        tick();
        checkOutput("redir_wait_rd", {31'd0, imem_rd}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hDEAD);
        tick();
        checkOutput("squash_valid", {31'd0, if_valid}, 32'd0);
        checkOutput("target_rd", {31'd0, imem_rd}, 32'd1);
        checkOutput("target_addr", {16'd0, imem_addr}, 32'h0040);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h4242);
        pushExp(16'h4242, 16'h0042);
        tick();
        popCheck("target", instruct, pc_inc, if_valid);

        // Halt stops fetch until reset
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        checkOutput("halt_halted", {31'd0, halted}, 32'd1);
        checkOutput("halt_instr", {16'd0, instruct}, {16'd0, NOP});
        checkOutput("halt_valid", {31'd0, if_valid}, 32'd0);
        for (int k = 0; k < 20; k++) begin
            checkOutput($sformatf("halt%0d_rd", k), {31'd0, imem_rd}, 32'd0);
            tick();
        end
        checkOutput("halt_still", {31'd0, halted}, 32'd1);
        checkOutput("main_err_clear", {31'd0, err}, 32'd0);

        // PC wrap and sticky error on the second instance
        rst_w = 1'b1;
        checkOutput("wrap_addr", {16'd0, imem_addr_w}, 32'hFFFE);
        checkOutput("wrap_rd", {31'd0, imem_rd_w}, 32'd1);
        imem_done_w = 1'b1;
        imem_data_w = 16'h7777;
        pushExp(16'h7777, 16'h0000);
        tick();
        popCheck("wrap", instruct_w, pc_inc_w, if_valid_w);
        checkOutput("wrap_next_addr", {16'd0, imem_addr_w}, 32'h0000);
        stall_w     = 1'b1;
        imem_data_w = 16'h9999;
        pushExp(16'h9999, 16'h0002);
        tick();
        checkOutput("full_err_before", {31'd0, err_w}, 32'd0);
        imem_data_w = 16'hBAD0;
        tick();
        checkOutput("spurious_err", {31'd0, err_w}, 32'd1);
        imem_done_w = 1'b0;
        stall_w     = 1'b0;
        tick();
        popCheck("wrap_skid", instruct_w, pc_inc_w, if_valid_w);
        tick();
        tick();
        checkOutput("err_sticky", {31'd0, err_w}, 32'd1);
        rst_w = 1'b0;
        #1;
        checkOutput("err_reset", {31'd0, err_w}, 32'd0);

        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
